// File: rtl/pipe_register_pkg.sv
// pipe_register_pkg
//   Shared limits and the elaboration-time parameter check for pipe_register.
//   No ports; imported by pipe_register and register_stage.
package pipe_register_pkg;

  localparam int unsigned PIPE_REGISTER_MAX_WIDTH = 64;
  localparam int unsigned PIPE_REGISTER_MAX_DEPTH = 16;

  // True when WIDTH and DEPTH fall inside the supported ranges.
  function automatic bit pipe_register_params_ok(input int unsigned width,
                                                 input int unsigned depth);
    return (width >= 1) && (width <= PIPE_REGISTER_MAX_WIDTH) &&
           (depth >= 1) && (depth <= PIPE_REGISTER_MAX_DEPTH);
  endfunction

endpackage

// File: rtl/register_stage.sv
// register_stage
//   One WIDTH-bit DFF bank with clock enable and synchronous reset to INIT.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous active-high reset, loads INIT (wins over ce)
//     ce    - clock enable; q holds when low
//     d     - next data
//     q     - registered data
module register_stage
  import pipe_register_pkg::*;
#(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= INIT;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// pipe_register
//   DEPTH-stage WIDTH-bit register chain with clock enable and synchronous
//   reset to INIT. Optional per-stage valid sideband when the macro
//   PIPE_REGISTER_VALID_EN is defined.
//   Ports:
//     CLK     - rising-edge clock
//     RESET   - synchronous active-high reset (stages -> INIT, valids -> 0)
//     CE      - clock enable; all stages hold when low
//     I       - data into stage 0
//     VALID_I - valid for I            (PIPE_REGISTER_VALID_EN only)
//     O       - last stage data
//     VALID_O - last stage valid       (PIPE_REGISTER_VALID_EN only)
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int unsigned      WIDTH = 7,
  parameter int unsigned      DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
`ifdef PIPE_REGISTER_VALID_EN
  input  logic             VALID_I,
  output logic             VALID_O,
`endif
  output logic [WIDTH-1:0] O
);

  if (!pipe_register_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("pipe_register: WIDTH=%0d DEPTH=%0d out of range", WIDTH, DEPTH);
  end

  // Element k feeds stage k; element DEPTH is the last stage output.
  logic [WIDTH-1:0] data_chain [DEPTH+1];

  assign data_chain[0] = I;
  assign O             = data_chain[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_data
    register_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk   (CLK),
      .reset (RESET),
      .ce    (CE),
      .d     (data_chain[k]),
      .q     (data_chain[k+1])
    );
  end

`ifdef PIPE_REGISTER_VALID_EN
  logic valid_chain [DEPTH+1];

  assign valid_chain[0] = VALID_I;
  assign VALID_O        = valid_chain[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_valid
    register_stage #(
      .WIDTH (1),
      .INIT  (1'b0)
    ) u_stage (
      .clk   (CLK),
      .reset (RESET),
      .ce    (CE),
      .d     (valid_chain[k]),
      .q     (valid_chain[k+1])
    );
  end
`endif

endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register
//   Bench for pipe_register: a WIDTH=7 DEPTH=3 INIT=7'h55 instance driven by
//   directed vectors, and a WIDTH=7 DEPTH=1 INIT=0 instance fed random data.
//   Valid checks exist only when PIPE_REGISTER_VALID_EN is defined.
module tb_pipe_register;

  typedef struct {
    int         tag;
    logic [6:0] o;
    logic       vo;
  } exp_t;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic [6:0] din = '0;
  logic       vin = 1'b0;
  logic [6:0] dout;
  logic       vout;

  // Compatibility instance
  logic       rst2 = 1'b1;
  logic [6:0] din2 = '0;
  logic [6:0] dout2;
`ifdef PIPE_REGISTER_VALID_EN
  logic       vout2;
`endif

  int checks = 0;
  int passes = 0;
  bit done1  = 1'b0;
  bit done2  = 1'b0;

  exp_t       q1[$];
  logic [6:0] q2[$];

  pipe_register #(.WIDTH(7), .DEPTH(3), .INIT(7'h55)) u_dut (
    .CLK     (clk),
    .RESET   (rst),
    .CE      (ce),
    .I       (din),
`ifdef PIPE_REGISTER_VALID_EN
    .VALID_I (vin),
    .VALID_O (vout),
`endif
    .O       (dout)
  );

`ifndef PIPE_REGISTER_VALID_EN
  assign vout = 1'b0;
`endif

  pipe_register #(.WIDTH(7), .DEPTH(1), .INIT(7'h00)) u_compat (
    .CLK     (clk),
    .RESET   (rst2),
    .CE      (1'b1),
    .I       (din2),
`ifdef PIPE_REGISTER_VALID_EN
    .VALID_I (1'b0),
    .VALID_O (vout2),
`endif
    .O       (dout2)
  );

  // Drive one cycle of stimulus and queue the values expected after the edge.
  task automatic step(input int tag, input logic r, input logic c,
                      input logic [6:0] i, input logic v,
                      input logic [6:0] eo, input logic evo);
    exp_t e;
    @(negedge clk);
    rst = r; ce = c; din = i; vin = v;
    e.tag = tag; e.o = eo; e.vo = evo;
    q1.push_back(e);
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    //    tag rst ce  I      VI   O      VO
    step( 1, 1, 1, 7'h7F, 1, 7'h55, 0);  // reset
    step( 2, 1, 1, 7'h7F, 1, 7'h55, 0);  // reset held
    step( 3, 0, 1, 7'd1,  1, 7'h55, 0);
    step( 4, 0, 1, 7'd2,  1, 7'h55, 0);
    step( 5, 0, 1, 7'd3,  1, 7'd1,  1);  // 3 edges after I=1
    step( 6, 0, 1, 7'd4,  1, 7'd2,  1);
    step( 7, 0, 0, 7'd9,  0, 7'd2,  1);  // stall x4
    step( 8, 0, 0, 7'd10, 0, 7'd2,  1);
    step( 9, 0, 0, 7'd11, 1, 7'd2,  1);
    step(10, 0, 0, 7'd12, 0, 7'd2,  1);
    step(11, 0, 1, 7'd5,  1, 7'd3,  1);  // resume, no loss/dup
    step(12, 0, 1, 7'd10, 1, 7'd4,  1);  // bubble pattern 1,0,1
    step(13, 0, 1, 7'd11, 0, 7'd5,  1);
    step(14, 0, 1, 7'd12, 1, 7'd10, 1);
    step(15, 0, 1, 7'd20, 1, 7'd11, 0);
    step(16, 0, 1, 7'd21, 1, 7'd12, 1);
    step(17, 0, 1, 7'd22, 1, 7'd20, 1);  // 20,21,22 in flight
    step(18, 1, 1, 7'd23, 1, 7'h55, 0);  // reset mid-flight, beats CE
    step(19, 0, 1, 7'd30, 1, 7'h55, 0);
    step(20, 0, 1, 7'd31, 1, 7'h55, 0);
    step(21, 0, 1, 7'd32, 1, 7'd30, 1);  // no 21/22 ever emerges
    step(22, 1, 0, 7'd40, 1, 7'h55, 0);  // reset with CE low
    step(23, 0, 0, 7'd41, 1, 7'h55, 0);  // disabled: not captured
    step(24, 0, 1, 7'd42, 1, 7'h55, 0);
    step(25, 0, 1, 7'd43, 1, 7'h55, 0);
    step(26, 0, 1, 7'd44, 1, 7'd42, 1);
    step(27, 0, 0, 7'd45, 0, 7'd42, 1);
    done1 = 1'b1;
  end

  // Compatibility stimulus: one reset cycle, then 100 random values.
  initial begin
    @(negedge clk);
    rst2 = 1'b1;
    din2 = 7'h3A;
    q2.push_back(7'h00);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      rst2 = 1'b0;
      din2 = 7'($urandom_range(0, 127));
      q2.push_back(din2);
    end
    done2 = 1'b1;
  end

  // Monitor for the main instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() != 0) begin
        e = q1.pop_front();
        checks++;
        if (dout === e.o) passes++;
        else $display("FAIL o_c%0d: got %h expected %h", e.tag, dout, e.o);
`ifdef PIPE_REGISTER_VALID_EN
        checks++;
        if (vout === e.vo) passes++;
        else $display("FAIL vo_c%0d: got %b expected %b", e.tag, vout, e.vo);
`endif
      end
    end
  end

  // Monitor for the compatibility instance.
  initial begin
    logic [6:0] e2;
    int         idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        checks++;
        if (dout2 === e2) passes++;
        else $display("FAIL compat_%0d: got %h expected %h", idx, dout2, e2);
        idx++;
      end
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!(done1 && done2) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (done1 && done2 && q1.size() == 0 && q2.size() == 0) passes++;
    else $display("FAIL drain: done=%0d%0d pending=%0d/%0d expected 11 and 0/0",
                  done1, done2, q1.size(), q2.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
# pipe_register

Parametrised multi-stage data register with clock enable, synchronous reset to a programmable value, and a valid sideband tracking occupancy per stage. It replaces fixed-width bare-DFF registers wherever the design needs a W-bit value delayed by N enabled clock cycles. Typical uses are board-pin capture, retiming stages and stallable datapath pipelines. It maps onto SB_DFFESR primitives on ice40.

## Interface
Parameters:
- WIDTH, 7: data width in bits; legal range 1..64.
- DEPTH, 1: number of register stages; legal range 1..16. DEPTH=0 is rejected at elaboration.
- INIT, 0: WIDTH-bit value loaded into every data stage on reset.

Ports:
- CLK  input  1  sole clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- CE  input  1  clock enable; when low, every stage holds.
- I  input  WIDTH  data into stage 0.
- VALID_I  input  1  marks I as meaningful (present only with PIPE_REGISTER_VALID_EN).
- O  output  WIDTH  output of the last stage (stage DEPTH-1).
- VALID_O  output  1  valid bit of the last stage (present only with PIPE_REGISTER_VALID_EN).

## Operation
- State: DEPTH data stages d[0..DEPTH-1], each WIDTH bits. Optionally DEPTH valid bits v[0..DEPTH-1].
- Priority per edge: RESET, then CE, then hold.
- RESET=1: every d[k] is set to INIT and every v[k] to 0, regardless of CE.
- RESET=0, CE=1:
  - d[0]<=I and v[0]<=VALID_I.
  - d[k]<=d[k-1] and v[k]<=v[k-1] for k>=1.
- RESET=0, CE=0: all stages hold. VALID_I and I are ignored that cycle (stall, not bubble insertion).
- O=d[DEPTH-1] and VALID_O=v[DEPTH-1]. Both are purely registered, with no combinational path from any input to any output.
- Data stages are not qualified by valid: they shift on CE even when VALID_I=0. This keeps data stages as plain DFFs with no extra enable logic.
- No arithmetic; widths pass through unchanged. INIT is truncated or zero-extended to WIDTH.

## Timing
- Reset values: O=INIT and VALID_O=0 from the first edge with RESET=1. Both hold until the first edge with RESET=0 and CE=1.
- Latency: a sample on I at an enabled edge appears on O after exactly DEPTH enabled edges; disabled edges do not count.
  - With DEPTH=1 and CE tied high, this is a one-cycle register, identical in behaviour to the plain Register<W>.
- Throughput: one sample per enabled cycle, with no bubbles introduced.
- Reset mid-operation: all in-flight samples are discarded on that edge. Stage 0 captures I at the first enabled edge after RESET falls.
- RESET and CE both high: reset wins; no sample is captured.
- CE toggling: stage contents are frozen across any run of CE=0 cycles and resume unchanged.

## Configuration
- Macro: PIPE_REGISTER_VALID_EN.
- Defined: VALID_I and VALID_O ports exist, and the v[] chain is built with the same CE/RESET rules as the data stages.
- Undefined: those ports and the v[] chain are absent. Data behaviour is bit-identical to the defined case.

## Structure
- Shared package pipe_register_pkg holds:
  - PIPE_REGISTER_MAX_WIDTH=64 and PIPE_REGISTER_MAX_DEPTH=16;
  - a function that checks the parameters, called at elaboration.
- One sub-module: register_stage (WIDTH, INIT). It is a single W-bit DFF bank with CE and synchronous reset-to-INIT. It is instantiated DEPTH times for data and DEPTH times at WIDTH=1, INIT=0 for valid.
- Top level is a generate loop chaining stages. There is no other logic.

## Test plan
WIDTH=7, DEPTH=3, INIT=7'h55 unless stated.
- Reset: hold RESET=1 for 2 cycles with CE=1 and I=7'h7F -> O=7'h55 and VALID_O=0 after the first edge, unchanged on the second.
- Latency: release reset, CE=1, drive I=1,2,3,4 with VALID_I=1 on consecutive cycles -> O=1 exactly 3 edges after I=1 was sampled, then 2,3,4. VALID_O rises on the same edge O=1 appears.
- Stall: mid-stream, hold CE=0 for 4 cycles -> O and VALID_O frozen for 4 cycles. The sequence resumes without loss or duplication once CE=1.
- Bubble: VALID_I pattern 1,0,1 with I=10,11,12 -> VALID_O pattern 1,0,1 and O=10,11,12, 3 cycles later.
- Reset mid-flight: pulse RESET=1 with CE=1 while 3 valid samples are in flight -> next edge O=7'h55 and VALID_O=0. No pre-reset sample ever appears.
- Compatibility: DEPTH=1, INIT=0, CE=1, macro undefined -> O equals I delayed by exactly one cycle for 100 random 7-bit values.
